hog_cell_hist: RTL and testbench
================================

# hog_cell_hist

Parametrised HOG cell-histogram engine, next generation of the `hog` front end. It accepts one pixel neighbourhood per cycle, in cell order, and computes the gradient, the unsigned orientation and the magnitude of each pixel. It accumulates magnitudes into NBIN orientation bins per CELL×CELL cell. Finished histograms stream out one bin per beat, and two ping-pong banks let the next cell fill while the previous one drains.

## Interface
- PIX_W, 8, pixel width.
- NBIN, 9, orientation bins over 0–180°, range 2..16.
- CELL, 8, cell edge in pixels; CELL×CELL pixels per cell.
- TAN_F, 8, fraction bits of the elaborated cos/sin boundary constants.
- BIN_W, 16, bin accumulator width; accumulators saturate.
- MAG_MODE, 0, magnitude: 0 = |gx|+|gy|, 1 = max+floor(min/2).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- ready  in  1  i_data valid this cycle.
- i_data  in  4*PIX_W  {top, bot, left, right} unsigned neighbours of the current pixel.
- request  out  1  block can accept a pixel; a pixel is accepted when ready && request.
- o_bin  out  BIN_W  bin value.
- o_idx  out  $clog2(NBIN)  bin index of o_bin, 0..NBIN-1.
- o_last  out  1  high on the beat with o_idx = NBIN-1.
- o_valid  out  1  o_bin/o_idx/o_last valid.
- i_ack  in  1  downstream takes the beat when o_valid && i_ack.

## Operation
- Gradient: gx = right−left, gy = bot−top, signed PIX_W+1.
- Fold to [0,180°): if gy<0, or gy==0 && gx<0, negate both.
- Boundaries: b_k = k·180/NBIN for k=1..NBIN-1.
  - C_k = round(cos b_k·2^TAN_F) and S_k = round(sin b_k·2^TAN_F), computed at elaboration.
  - Crossed when gy·C_k − gx·S_k ≥ 0.
  - bin = number of boundaries crossed.
  - gx=gy=0 gives bin 0 and magnitude 0.
- Magnitude: unsigned PIX_W+2 bits per MAG_MODE; floor division in mode 1.
- Accumulate: bank[bin] += mag, saturating at 2^BIN_W−1.
- Banks: A and B, each NBIN×BIN_W, each in state FREE, FILL or FULL/DRAIN.
  - A pixel counter 0..CELL²−1 selects the filling bank.
  - Accepting pixel CELL²−1 wraps the counter and toggles the fill pointer to the other bank.
  - Every pipeline entry carries its bank tag, so in-flight pixels of the old cell still land in the old bank.
- A bank becomes FULL when its last pixel is accumulated.
- Drain order: FULL banks in fill order, bins 0..NBIN−1.
  - Each accepted beat clears that bin.
  - The beat with o_last frees the bank.
- request = 1 iff the bank under the fill pointer is FREE or FILL. It is registered, so it depends on state only.
- Simultaneous events:
  - A bank freed on the same edge the fill pointer toggles onto it gives request=1 on the next cycle.
  - A drain beat and an accumulate never target the same bank.

## Timing
- Pipeline, with E0 the edge that accepts a pixel:
  - E0: register gx/gy (folded) and the bank tag.
  - E1: register mag and bin.
  - E2: bank update.
- Throughput: 1 pixel/cycle sustained when downstream acks every beat.
- The first o_valid of a cell is visible in the cycle after E2 of its last pixel.
- Drain: NBIN cycles at i_ack=1. Back-to-back cells drain with no bubble between o_last and the next bin 0.
- While o_valid && !i_ack, o_bin, o_idx and o_last hold stable.
- Reset (rst=0 sampled):
  - request=0, o_valid=0, o_bin=0, o_idx=0, o_last=0.
  - Banks zeroed, both FREE; pixel counter and pipeline cleared.
  - request=1 from the first edge with rst=1.
  - Reset mid-fill or mid-drain discards everything; no partial beats follow.
- ready is ignored while request=0. Pixels offered then are not counted.

## Test plan
- Defaults, 64× {83h,78h,26h,57h} (gx=−49, gy=11 folded, 167°, L1 60) -> one histogram: bin8=3840, others 0, o_last on idx 8.
- 64× {0,9,0,6} (56°, L1 15) -> bin2=960. Same pixels with MAG_MODE=1 -> bin2=768.
- 64× {0,9,0,0} (90°) -> bin4=576. 64× {5,5,5,5} -> all bins 0.
- BIN_W=10, 64× {83h,78h,26h,57h} -> bin8=1023 (saturated).
- i_ack=0, ready=1 continuous -> request falls one cycle after the 128th accept. Release i_ack -> 9 beats of cell 1 then 9 beats of cell 2 with no gap, and request=1 again after the first o_last. Randomly toggling i_ack -> beats stable while stalled.
- rst=0 during bin 3 of a drain -> outputs zero next edge. After release, a fresh cell yields a clean histogram with no residue.

Source files
------------

// File: rtl/hog_cell_hist.sv
// rtl/hog_cell_hist.sv - HOG orientation histogram per cell with ping-pong bin banks
module hog_cell_hist #(
    parameter int PIX_W    = 8,
    parameter int NBIN     = 9,
    parameter int CELL     = 8,
    parameter int TAN_F    = 8,
    parameter int BIN_W    = 16,
    parameter int MAG_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ready,
    input  logic [4*PIX_W-1:0]      i_data,
    output logic                    request,
    output logic [BIN_W-1:0]        o_bin,
    output logic [$clog2(NBIN)-1:0] o_idx,
    output logic                    o_last,
    output logic                    o_valid,
    input  logic                    i_ack
);
    localparam int GW    = PIX_W + 1;
    localparam int MW    = PIX_W + 2;
    localparam int NPIX  = CELL * CELL;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int IDX_W = $clog2(NBIN);
    localparam int SUM_W = ((BIN_W > MW) ? BIN_W : MW) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPIX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBIN - 1);

    function automatic real trig(input int k, input bit sine);
        real x, term, acc;
        x = 3.14159265358979324 * real'(k) / real'(NBIN);
        term = sine ? x : 1.0;
        acc  = term;
        for (int i = 1; i < 24; i++) begin
            if (sine) term = -term * x * x / real'((2 * i) * (2 * i + 1));
            else      term = -term * x * x / real'((2 * i - 1) * (2 * i));
            acc = acc + term;
        end
        return acc;
    endfunction

    function automatic int q_round(input real v);
        real s;
        s = v * (2.0 ** TAN_F);
        return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
    endfunction

    // B_WAIT: cell closed (fill pointer moved on) but its last pixels are still in flight
    typedef enum logic [1:0] {B_FREE, B_FILL, B_WAIT, B_FULL} bank_st_t;

    bank_st_t         st [2];
    bank_st_t         st_n [2];
    logic [BIN_W-1:0] bank [2][NBIN];
    logic             fp, fp_n, dp;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] d_idx;

    logic                 s1_valid, s1_tag, s1_last;
    logic signed [GW-1:0] s1_gx, s1_gy;
    logic                 s2_valid, s2_tag, s2_last;
    logic [MW-1:0]        s2_mag;
    logic [IDX_W-1:0]     s2_bin;

    logic [PIX_W-1:0]     top, bot, lft, rgt;
    logic signed [GW-1:0] gx_raw, gy_raw;
    logic                 flip, accept, beat;

    assign {top, bot, lft, rgt} = i_data;
    assign gx_raw = $signed({1'b0, rgt}) - $signed({1'b0, lft});
    assign gy_raw = $signed({1'b0, bot}) - $signed({1'b0, top});
    assign flip   = (gy_raw < 0) || (gy_raw == 0 && gx_raw < 0);
    assign accept = ready && request;

    assign o_valid = (st[dp] == B_FULL);
    assign o_bin   = bank[dp][d_idx];
    assign o_idx   = d_idx;
    assign o_last  = o_valid && (d_idx == IDX_LAST);
    assign beat    = o_valid && i_ack;

    // Boundary k is crossed when the folded gradient lies at or past angle k*180/NBIN
    logic [NBIN-2:0] crossed;
    for (genvar k = 1; k < NBIN; k++) begin : g_bnd
        localparam int CK = q_round(trig(k, 1'b0));
        localparam int SK = q_round(trig(k, 1'b1));
        assign crossed[k-1] = (int'(s1_gy) * CK - int'(s1_gx) * SK) >= 0;
    end

    logic [GW-1:0]    ax, ay, hi, lo;
    logic [MW-1:0]    mag_c;
    logic [IDX_W-1:0] bin_c;

    always_comb begin
        ax = s1_gx[GW-1] ? -s1_gx : s1_gx;
        ay = s1_gy;
        hi = (ax > ay) ? ax : ay;
        lo = (ax > ay) ? ay : ax;
        if (MAG_MODE == 1) mag_c = MW'(hi) + MW'(lo >> 1);
        else               mag_c = MW'(ax) + MW'(ay);
        bin_c = '0;
        for (int k = 0; k < NBIN - 1; k++) bin_c = bin_c + IDX_W'(crossed[k]);
        if (s1_gx == 0 && s1_gy == 0) bin_c = '0;
    end

    logic [BIN_W-1:0] cur, upd;
    logic [SUM_W-1:0] sum;

    always_comb begin
        cur = bank[s2_tag][s2_bin];
        sum = SUM_W'(cur) + SUM_W'(s2_mag);
        upd = (sum > SUM_W'({BIN_W{1'b1}})) ? {BIN_W{1'b1}} : sum[BIN_W-1:0];
    end

    always_comb begin
        st_n = st;
        fp_n = fp;
        if (s2_valid && s2_last) st_n[s2_tag] = B_FULL;
        if (beat && d_idx == IDX_LAST) st_n[dp] = B_FREE;
        if (accept) begin
            if (cnt == CNT_LAST) begin
                st_n[fp] = B_WAIT;
                fp_n     = ~fp;
            end else if (st[fp] == B_FREE) begin
                st_n[fp] = B_FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st[0]    <= B_FREE;
            st[1]    <= B_FREE;
            fp       <= 1'b0;
            dp       <= 1'b0;
            cnt      <= '0;
            d_idx    <= '0;
            request  <= 1'b0;
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            s1_last  <= 1'b0;
            s1_gx    <= '0;
            s1_gy    <= '0;
            s2_valid <= 1'b0;
            s2_tag   <= 1'b0;
            s2_last  <= 1'b0;
            s2_mag   <= '0;
            s2_bin   <= '0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NBIN; i++) bank[b][i] <= '0;
        end else begin
            st      <= st_n;
            fp      <= fp_n;
            request <= (st_n[fp_n] == B_FREE) || (st_n[fp_n] == B_FILL);

            s1_valid <= accept;
            if (accept) begin
                cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                s1_gx   <= flip ? -gx_raw : gx_raw;
                s1_gy   <= flip ? -gy_raw : gy_raw;
                s1_tag  <= fp;
                s1_last <= (cnt == CNT_LAST);
            end

            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_last  <= s1_last;
            s2_mag   <= mag_c;
            s2_bin   <= bin_c;

            if (s2_valid) bank[s2_tag][s2_bin] <= upd;

            // The draining bank is FULL and never the accumulate target, so the writes never collide
            if (beat) begin
                bank[dp][d_idx] <= '0;
                if (d_idx == IDX_LAST) begin
                    d_idx <= '0;
                    dp    <= ~dp;
                end else begin
                    d_idx <= d_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_hog_cell_hist.sv
// tb/tb_hog_cell_hist.sv - self-checking bench for hog_cell_hist against a histogram reference model
module tb_hog_cell_hist;
    localparam int NBIN = 9;
    localparam int NPIX = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ready = 1'b0;
    logic        i_ack = 1'b1;
    logic [31:0] i_data = '0;
    logic        rq [3];
    logic        ov [3];
    logic        ol [3];
    logic [3:0]  oi [3];
    logic [15:0] ob0, ob1;
    logic [9:0]  ob2;

    hog_cell_hist dut0 (.clk(clk), .rst(rst), .ready(ready), .i_data(i_data), .request(rq[0]),
        .o_bin(ob0), .o_idx(oi[0]), .o_last(ol[0]), .o_valid(ov[0]), .i_ack(i_ack));
    hog_cell_hist #(.MAG_MODE(1)) dut1 (.clk(clk), .rst(rst), .ready(ready), .i_data(i_data), .request(rq[1]),
        .o_bin(ob1), .o_idx(oi[1]), .o_last(ol[1]), .o_valid(ov[1]), .i_ack(i_ack));
    hog_cell_hist #(.BIN_W(10)) dut2 (.clk(clk), .rst(rst), .ready(ready), .i_data(i_data), .request(rq[2]),
        .o_bin(ob2), .o_idx(oi[2]), .o_last(ol[2]), .o_valid(ov[2]), .i_ack(i_ack));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit ack_rand = 1'b0;

    int ck [NBIN];
    int sk [NBIN];
    int hist [3][NBIN];
    int maxv [3] = '{65535, 65535, 1023};
    int pcnt = 0;
    int q [3][$];
    int beat [3] = '{0, 0, 0};
    bit held [3] = '{0, 0, 0};
    int hb [3], hix [3], hl [3];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] bin_of(input int d);
        case (d)
            0:       return ob0;
            1:       return ob1;
            default: return {6'd0, ob2};
        endcase
    endfunction

    // Reference: fold the gradient, count boundary crossings, then accumulate per configuration
    task automatic model_pixel(input logic [31:0] d);
        int t, b, l, r, gx, gy, ax, bin, mx, mn;
        int m [3];
        t = int'(d[31:24]); b = int'(d[23:16]); l = int'(d[15:8]); r = int'(d[7:0]);
        gx = r - l;
        gy = b - t;
        if (gy < 0 || (gy == 0 && gx < 0)) begin
            gx = -gx;
            gy = -gy;
        end
        bin = 0;
        if (!(gx == 0 && gy == 0))
            for (int k = 1; k < NBIN; k++)
                if (gy * ck[k] - gx * sk[k] >= 0) bin++;
        ax = (gx < 0) ? -gx : gx;
        mx = (ax > gy) ? ax : gy;
        mn = (ax > gy) ? gy : ax;
        m[0] = ax + gy;
        m[1] = mx + mn / 2;
        m[2] = ax + gy;
        for (int dd = 0; dd < 3; dd++) begin
            hist[dd][bin] = hist[dd][bin] + m[dd];
            if (hist[dd][bin] > maxv[dd]) hist[dd][bin] = maxv[dd];
        end
        pcnt++;
        if (pcnt == NPIX) begin
            pcnt = 0;
            for (int dd = 0; dd < 3; dd++)
                for (int i = 0; i < NBIN; i++) begin
                    q[dd].push_back(hist[dd][i]);
                    hist[dd][i] = 0;
                end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pcnt = 0;
            for (int d = 0; d < 3; d++) begin
                q[d].delete();
                beat[d] = 0;
                held[d] = 1'b0;
                for (int i = 0; i < NBIN; i++) hist[d][i] = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                logic [15:0] bv;
                int exp_v;
                bv = bin_of(d);
                if (held[d]) begin
                    check("hold_valid", ov[d], 1);
                    check("hold_bin", bv, hb[d]);
                    check("hold_idx", oi[d], hix[d]);
                    check("hold_last", ol[d], hl[d]);
                end
                held[d] = ov[d] && !i_ack;
                hb[d] = int'(bv);
                hix[d] = int'(oi[d]);
                hl[d] = int'(ol[d]);
                if (ov[d] && i_ack) begin
                    check("beat_expected", q[d].size() > 0, 1);
                    if (q[d].size() > 0) begin
                        exp_v = q[d].pop_front();
                        check("bin_value", bv, exp_v);
                        check("bin_idx", oi[d], beat[d]);
                        check("bin_last", ol[d], beat[d] == NBIN - 1);
                        beat[d] = (beat[d] + 1) % NBIN;
                    end
                end
            end
            if (ready && rq[0]) model_pixel(i_data);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_rand) i_ack = 1'($urandom_range(0, 1));
        end
    end

    task automatic put_pix(input logic [31:0] d, input bit gaps);
        int n;
        bit got;
        if (gaps) begin
            n = $urandom_range(0, 3);
            if (n > 0) begin
                ready = 1'b0;
                i_data = $urandom;
                repeat (n) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        ready = 1'b1;
        i_data = d;
        got = 1'b0;
        for (int t = 0; t < 4000 && !got; t++) begin
            @(negedge clk);
            got = (rq[0] === 1'b1) && rst;
            @(posedge clk);
            #1;
        end
        if (!got) check("accept_timeout", got, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            done = (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && !ov[0]);
        end
        check("drain_done", done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation bound reached at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        bit found;
        logic [7:0] px;
        for (int k = 1; k < NBIN; k++) begin
            real ang;
            ang = 3.141592653589793 * real'(k) / real'(NBIN);
            ck[k] = $rtoi($floor($cos(ang) * 256.0 + 0.5));
            sk[k] = $rtoi($floor($sin(ang) * 256.0 + 0.5));
        end

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_request", rq[0], 0);
        check("rst_valid", ov[0], 0);
        check("rst_bin", ob0, 0);
        check("rst_idx", oi[0], 0);
        check("rst_last", ol[0], 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("request_after_reset", rq[0], 1);
        @(posedge clk);
        #1;

        // single cell, with first-beat latency after the last pixel
        repeat (NPIX) put_pix(32'h83782657, 1'b0);
        ready = 1'b0;
        @(negedge clk); check("latency_e0", ov[0], 0);
        @(negedge clk); check("latency_e1", ov[0], 0);
        @(negedge clk); check("latency_e2", ov[0], 1);
        @(posedge clk);
        #1;
        wait_idle();

        c0 = cyc;
        repeat (NPIX) put_pix(32'h00090006, 1'b0);
        repeat (NPIX) put_pix(32'h00090000, 1'b0);
        repeat (NPIX) put_pix(32'h05050505, 1'b0);
        ready = 1'b0;
        check("throughput_cycles", cyc - c0, 3 * NPIX);
        wait_idle();

        // downstream stalled: both banks fill, then request drops
        i_ack = 1'b0;
        repeat (2 * NPIX) put_pix($urandom, 1'b0);
        @(negedge clk);
        check("request_fall", rq[0], 0);
        repeat (10) begin
            @(negedge clk);
            check("request_held_low", rq[0], 0);
        end
        @(posedge clk);
        #1;
        ready = 1'b0;
        i_ack = 1'b1;
        for (int i = 0; i < 2 * NBIN; i++) begin
            @(negedge clk);
            check("drain_no_gap", ov[0], 1);
            if (i == NBIN - 1) check("request_before_last", rq[0], 0);
            if (i == NBIN) check("request_after_last", rq[0], 1);
        end
        @(posedge clk);
        #1;
        wait_idle();

        ack_rand = 1'b1;
        for (int i = 0; i < 5 * NPIX; i++) begin
            px = 8'($urandom);
            put_pix(($urandom_range(0, 7) == 0) ? {4{px}} : $urandom, 1'b1);
        end
        ready = 1'b0;
        ack_rand = 1'b0;
        i_ack = 1'b1;
        wait_idle();

        // reset while bin 3 of a cell is on the output
        repeat (NPIX) put_pix($urandom, 1'b0);
        ready = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(posedge clk);
            #1;
            if (ov[0] && oi[0] == 4'd3) found = 1'b1;
        end
        check("reached_bin3", found, 1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", ov[0], 0);
        check("midrst_bin", ob0, 0);
        check("midrst_idx", oi[0], 0);
        check("midrst_last", ol[0], 0);
        check("midrst_request", rq[0], 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (NPIX) put_pix(32'h00090006, 1'b0);
        ready = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
